streaming_fifo_v2: RTL

Parametrised AXI-Stream FIFO, the successor to the fixed-configuration streaming FIFO. It sits between dataflow layers and decouples producer and consumer with configurable width and depth, including non-power-of-two depths. It adds a first-word-fall-through output stage backed by a synchronous-read RAM, plus programmable almost-full/almost-empty flags. An occupancy high-water mark can be compiled in.

---
 rtl/streaming_fifo_pkg.sv | 23 ++
 rtl/fifo_sdp_ram.sv | 27 ++
 rtl/streaming_fifo_v2.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/streaming_fifo_pkg.sv
// Shared types and helpers for streaming_fifo_v2: prefetch state encoding,
// count/pointer width derivation and non-power-of-two pointer wrap.
package streaming_fifo_pkg;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_ONE   = 2'd1,
    PF_TWO   = 2'd2
  } pf_state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned last);
    return (ptr >= last) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Read-during-write to the same address returns the previous contents.
module fifo_sdp_ram #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ENTRIES = 30,
  parameter int unsigned AW      = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/streaming_fifo_v2.sv
// AXI-Stream FIFO: synchronous-read RAM plus 2-entry FWFT prefetch buffer,
// registered count/threshold flags. Optional high-water mark: STREAMING_FIFO_OCC_STATS_EN.
module streaming_fifo_v2
  import streaming_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_THRESH = DEPTH - 4,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned CNT_W     = cnt_width(DEPTH)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
`ifdef STREAMING_FIFO_OCC_STATS_EN
  output logic [CNT_W-1:0] max_count,
  input  logic             clr_max,
`endif
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned RAM_D = DEPTH - 2;
  localparam int unsigned PTR_W = ptr_width(RAM_D);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  pf_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             tready_q, tready_d, af_q, af_d, ae_q, ae_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             push, pop, rd_issue;
  logic [1:0]       buf_cnt, occ;
`ifdef STREAMING_FIFO_OCC_STATS_EN
  logic [CNT_W-1:0] max_q, max_d;
`endif

  fifo_sdp_ram #(
    .WIDTH  (WIDTH),
    .ENTRIES(RAM_D),
    .AW     (PTR_W)
  ) u_ram (
    .clk    (ap_clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(in0_V_V_TDATA),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rdata)
  );

  always_comb begin
    push = in0_V_V_TVALID && tready_q;
    pop  = (state_q != PF_EMPTY) && out_V_V_TREADY;

    unique case (state_q)
      PF_ONE:  buf_cnt = 2'd1;
      PF_TWO:  buf_cnt = 2'd2;
      default: buf_cnt = 2'd0;
    endcase
    occ = buf_cnt + {1'b0, inflight_q};
    // A pop this cycle frees a slot, so refill immediately to avoid a bubble
    rd_issue = (ram_cnt_q != '0) && (pop || (occ < 2'd2));

    wr_ptr_d   = push     ? PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), RAM_D - 1)) : wr_ptr_q;
    rd_ptr_d   = rd_issue ? PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), RAM_D - 1)) : rd_ptr_q;
    inflight_d = rd_issue;

    unique case ({push, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    tready_d = count_d < DEPTH_C;
    af_d     = count_d >= AF_C;
    ae_d     = count_d <= AE_C;

    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      PF_EMPTY: begin
        if (inflight_q) begin
          head_d  = ram_rdata;
          state_d = PF_ONE;
        end
      end
      PF_ONE: begin
        if (inflight_q && !pop) begin
          tail_d  = ram_rdata;
          state_d = PF_TWO;
        end else if (inflight_q && pop) begin
          head_d = ram_rdata;
        end else if (pop) begin
          state_d = PF_EMPTY;
        end
      end
      PF_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = PF_ONE;
        end
      end
      default: state_d = PF_EMPTY;
    endcase

`ifdef STREAMING_FIFO_OCC_STATS_EN
    max_d = max_q;
    if (clr_max)              max_d = count_d;
    else if (count_d > max_q) max_d = count_d;
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= PF_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      tready_q   <= 1'b0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
`ifdef STREAMING_FIFO_OCC_STATS_EN
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tready_q   <= tready_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
`ifdef STREAMING_FIFO_OCC_STATS_EN
      max_q      <= max_d;
`endif
    end
  end

  assign in0_V_V_TREADY = tready_q;
  assign out_V_V_TDATA  = head_q;
  assign out_V_V_TVALID = (state_q != PF_EMPTY);
  assign count          = count_q;
  assign almost_full    = af_q;
  assign almost_empty   = ae_q;
`ifdef STREAMING_FIFO_OCC_STATS_EN
  assign max_count      = max_q;
`endif

endmodule
